// File: rtl/tf_seq_ctrl.sv
// tf_seq_ctrl: twiddle-factor generator sequencer.
// Walks every NTT stage l and every twiddle group (ite_sw_cnt) of that stage,
// DEPTH beats per group, with a DRAIN_CYC idle gap after each stage, then
// pulses done. All outputs are registered; the counters visible in a cycle
// always describe the beat whose TF_ren is high in that same cycle.
// Optional feature macro: TF_SEQ_CTRL_PERF_EN (builds the cycle_cnt counter).
module tf_seq_ctrl #(
  parameter int D_WIDTH    = 64,
  parameter int LOG_DEGREE = 10,
  parameter int RADIX_K1   = 4,
  parameter int DEPTH      = 4,
  parameter int DRAIN_CYC  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  output logic               busy,
  output logic               done,
  output logic               TF_ren,
  output logic               TF_wen,
  output logic [2:0]         it_depth_cnt,
  output logic [2:0]         l,
  output logic               LAST_STAGE,
  output logic [D_WIDTH-1:0] ite_sw_cnt,
  output logic [D_WIDTH-1:0] ite_sw_cnt_ite3,
  output logic [31:0]        cycle_cnt
);

  localparam int NUM_STAGES = (LOG_DEGREE + RADIX_K1 - 1) / RADIX_K1;
  localparam int DC_W       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [2:0]      LAST_L    = 3'(NUM_STAGES - 1);
  localparam logic [2:0]      LAST_BEAT = 3'(DEPTH - 1);
  localparam logic [DC_W-1:0] DC_LAST   = DC_W'(DRAIN_CYC - 1);

  // Parameter sanity: the 3-bit beat/stage outputs and the group counter
  // width bound what can be sequenced.
  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("tf_seq_ctrl: DEPTH must be in 1..8");
  end
  if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
    $error("tf_seq_ctrl: NUM_STAGES must be in 1..8");
  end
  if (RADIX_K1 * (NUM_STAGES - 1) > D_WIDTH) begin : g_bad_width
    $error("tf_seq_ctrl: G(l) overflows D_WIDTH");
  end
  if (DRAIN_CYC < 1) begin : g_bad_drain
    $error("tf_seq_ctrl: DRAIN_CYC must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic              fresh;   // RUN entered, first beat of the stage not yet issued
  logic [DC_W-1:0]   dcnt;
  logic [D_WIDTH-1:0] g_last;
  logic              beat_last, stage_end;
  logic [2:0]        adv_it;
  logic [D_WIDTH-1:0] adv_ite;
  logic [2:0]        l_inc;

  // Beat/group stepping from the beat currently on the outputs.
  always_comb begin
    g_last    = ~({D_WIDTH{1'b1}} << (RADIX_K1 * int'(l)));
    beat_last = (it_depth_cnt == LAST_BEAT);
    stage_end = beat_last && (ite_sw_cnt == g_last);
    adv_it    = beat_last ? 3'd0 : it_depth_cnt + 3'd1;
    adv_ite   = beat_last ? ite_sw_cnt + D_WIDTH'(1) : ite_sw_cnt;
    l_inc     = l + 3'd1;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      fresh           <= 1'b0;
      dcnt            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      TF_ren          <= 1'b0;
      TF_wen          <= 1'b0;
      it_depth_cnt    <= '0;
      l               <= '0;
      LAST_STAGE      <= 1'b0;
      ite_sw_cnt      <= '0;
      ite_sw_cnt_ite3 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state           <= RUN;
            fresh           <= 1'b1;
            busy            <= 1'b1;
            dcnt            <= '0;
            l               <= '0;
            LAST_STAGE      <= (LAST_L == 3'd0);
            it_depth_cnt    <= '0;
            ite_sw_cnt      <= '0;
            ite_sw_cnt_ite3 <= '0;
            TF_ren          <= 1'b0;
            TF_wen          <= 1'b0;
          end
        end
        RUN: begin
          if (stall) begin
            // Freeze on the current beat; resume re-steps from it.
            TF_ren <= 1'b0;
            TF_wen <= 1'b0;
          end else if (fresh) begin
            // Counters are already zero: issue beat 0 of group 0.
            fresh  <= 1'b0;
            TF_ren <= 1'b1;
            TF_wen <= 1'b1;
          end else if (stage_end) begin
            state           <= DRAIN;
            dcnt            <= '0;
            TF_ren          <= 1'b0;
            TF_wen          <= 1'b0;
            it_depth_cnt    <= '0;
            ite_sw_cnt      <= '0;
            ite_sw_cnt_ite3 <= '0;
          end else begin
            TF_ren          <= 1'b1;
            TF_wen          <= (adv_it == 3'd0);
            it_depth_cnt    <= adv_it;
            ite_sw_cnt      <= adv_ite;
            ite_sw_cnt_ite3 <= adv_ite >> RADIX_K1;
          end
        end
        DRAIN: begin
          if (dcnt != DC_LAST) begin
            dcnt <= dcnt + DC_W'(1);
          end else if (LAST_STAGE) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            // Next stage starts directly on its first beat unless stalled.
            state      <= RUN;
            dcnt       <= '0;
            l          <= l_inc;
            LAST_STAGE <= (l_inc == LAST_L);
            fresh      <= stall;
            TF_ren     <= !stall;
            TF_wen     <= !stall;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TF_SEQ_CTRL_PERF_EN
  // Counts sequencing edges from start acceptance through the done edge;
  // the DONE->IDLE edge is not counted, so the value held equals the done cycle.
  always_ff @(posedge clk) begin
    if (rst)
      cycle_cnt <= '0;
    else if (state == IDLE && start)
      cycle_cnt <= '0;
    else if (state == RUN || state == DRAIN)
      cycle_cnt <= cycle_cnt + 32'd1;
  end
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_tf_seq_ctrl.sv
// Bench for tf_seq_ctrl: a trace model generated from the sequencing rules
// (stage/group/beat loops, stall holds, drain gaps) is compared cycle by cycle.
module tb_tf_seq_ctrl;

  localparam int NS    = 3;
  localparam int RK    = 4;
  localparam int DEPTH = 4;
  localparam int DRAIN = 3;
  localparam int MAXC  = 4096;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        ren;
    logic        wen;
    logic [2:0]  it;
    logic [2:0]  l;
    logic        last;
    logic [63:0] ite;
    logic [63:0] ite3;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        busy, done, TF_ren, TF_wen, LAST_STAGE;
  logic [2:0]  it_depth_cnt, l;
  logic [63:0] ite_sw_cnt, ite_sw_cnt_ite3;
  logic [31:0] cycle_cnt;

  int   errors = 0;
  int   checks = 0;
  rec_t obs;
  rec_t exp_a [0:MAXC-1];
  int   exp_n;
  bit   stall_at [0:MAXC-1];

`ifdef TF_SEQ_CTRL_PERF_EN
  localparam logic [31:0] PERF_EXP = 32'd1102;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  tf_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .busy(busy), .done(done), .TF_ren(TF_ren), .TF_wen(TF_wen),
    .it_depth_cnt(it_depth_cnt), .l(l), .LAST_STAGE(LAST_STAGE),
    .ite_sw_cnt(ite_sw_cnt), .ite_sw_cnt_ite3(ite_sw_cnt_ite3),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    obs.busy = busy; obs.done = done; obs.ren = TF_ren; obs.wen = TF_wen;
    obs.it = it_depth_cnt; obs.l = l; obs.last = LAST_STAGE;
    obs.ite = ite_sw_cnt; obs.ite3 = ite_sw_cnt_ite3;
  endtask

  task automatic push(input rec_t r);
    if (exp_n < MAXC) begin
      exp_a[exp_n] = r;
      exp_n++;
    end
  endtask

  // Expected trace, index = cycles after the start-sampling edge.
  task automatic build_model();
    rec_t cur;
    rec_t frz;
    cur = '0;
    cur.busy = 1'b1;
    cur.last = (NS == 1);
    exp_n = 0;
    push(cur);
    for (int s = 0; s < NS; s++) begin
      cur.l = 3'(s);
      cur.last = (s == NS - 1);
      for (int g = 0; g < (1 << (RK * s)); g++) begin
        for (int d = 0; d < DEPTH; d++) begin
          while (stall_at[exp_n] && exp_n < MAXC) begin
            frz = cur; frz.ren = 1'b0; frz.wen = 1'b0;
            push(frz);
          end
          cur.it = 3'(d); cur.ite = 64'(g); cur.ite3 = 64'(g >> RK);
          cur.ren = 1'b1; cur.wen = (d == 0);
          push(cur);
        end
      end
      while (stall_at[exp_n] && exp_n < MAXC) begin
        frz = cur; frz.ren = 1'b0; frz.wen = 1'b0;
        push(frz);
      end
      cur.ren = 1'b0; cur.wen = 1'b0; cur.it = '0; cur.ite = '0; cur.ite3 = '0;
      for (int k = 0; k < DRAIN; k++) push(cur);
    end
    cur.done = 1'b1;
    push(cur);
    cur.done = 1'b0;
    cur.busy = 1'b0;
    for (int k = 0; k < 3; k++) push(cur);
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < MAXC; i++) stall_at[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== rec_t'(0)) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", obs);
    end
    checks++;
    if (cycle_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cycle_cnt got=%0d exp=0", cycle_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    int dcount = 0, dcyc = -1, fall = -1;
    clear_stalls();
    build_model();
    for (int n = 0; n < exp_n; n++) begin
      start = (n == 0); stall = 1'b0;
      tick();
      checks++;
      if (obs !== exp_a[n]) begin
        errors++;
        if (errors < 40) $display("FAIL nominal_trace cyc=%0d got=%h exp=%h", n, obs, exp_a[n]);
      end
      if (n == 1 || n == 8 || n == 12 || n == 75) begin
        checks++;
        if (obs.wen !== 1'b1) begin errors++; $display("FAIL wen_cyc%0d got=%b exp=1", n, obs.wen); end
      end
      if (n == 74 || n == 75) begin
        checks++;
        if (obs.last !== (n == 75)) begin errors++; $display("FAIL last_stage_cyc%0d got=%b exp=%b", n, obs.last, n == 75); end
      end
      if (n == 11) begin
        checks++;
        if (obs.it !== 3'd3 || obs.ite !== 64'd0) begin errors++; $display("FAIL bnd11 got it=%0d ite=%0d exp it=3 ite=0", obs.it, obs.ite); end
      end
      if (n == 12) begin
        checks++;
        if (obs.it !== 3'd0 || obs.ite !== 64'd1 || obs.wen !== 1'b1) begin
          errors++; $display("FAIL bnd12 got it=%0d ite=%0d wen=%b exp 0/1/1", obs.it, obs.ite, obs.wen);
        end
      end
      if (n == 71) begin
        checks++;
        if (obs.ite !== 64'd15) begin errors++; $display("FAIL bnd71 got ite=%0d exp=15", obs.ite); end
      end
      if (n == 72) begin
        checks++;
        if (obs.ren !== 1'b0) begin errors++; $display("FAIL bnd72 got ren=%b exp=0", obs.ren); end
      end
      if (obs.done === 1'b1) begin dcount++; dcyc = n; end
      if (n > 0 && fall < 0 && obs.busy !== 1'b1) fall = n;
    end
    start = 1'b0;
    checks++;
    if (dcount != 1 || dcyc != 1102) begin errors++; $display("FAIL nominal_done got count=%0d cyc=%0d exp 1/1102", dcount, dcyc); end
    checks++;
    if (fall != 1103) begin errors++; $display("FAIL busy_fall got=%0d exp=1103", fall); end
    checks++;
    if (cycle_cnt !== PERF_EXP) begin errors++; $display("FAIL perf_cnt got=%0d exp=%0d", cycle_cnt, PERF_EXP); end
    tick(); tick();
    checks++;
    if (cycle_cnt !== PERF_EXP) begin errors++; $display("FAIL perf_hold got=%0d exp=%0d", cycle_cnt, PERF_EXP); end
  endtask

  task automatic test_stall_window();
    int dcyc = -1;
    clear_stalls();
    for (int i = 20; i <= 24; i++) stall_at[i] = 1'b1;
    build_model();
    for (int n = 0; n < exp_n; n++) begin
      start = (n == 0); stall = stall_at[n];
      tick();
      checks++;
      if (obs !== exp_a[n]) begin
        errors++;
        if (errors < 40) $display("FAIL stall_trace cyc=%0d got=%h exp=%h", n, obs, exp_a[n]);
      end
      if (n >= 20 && n <= 24) begin
        checks++;
        if (obs.ren !== 1'b0 || obs.wen !== 1'b0 || obs.it !== 3'd3 || obs.ite !== 64'd2) begin
          errors++; $display("FAIL stall_frozen cyc=%0d got ren=%b wen=%b it=%0d ite=%0d exp 0/0/3/2", n, obs.ren, obs.wen, obs.it, obs.ite);
        end
      end
      if (obs.done === 1'b1) dcyc = n;
    end
    start = 1'b0; stall = 1'b0;
    checks++;
    if (dcyc != 1107) begin errors++; $display("FAIL stall_done got=%0d exp=1107", dcyc); end
  endtask

  task automatic test_random_stall();
    int dcount = 0;
    clear_stalls();
    for (int i = 1; i < 1400; i++) stall_at[i] = ($urandom_range(0, 5) == 0);
    build_model();
    for (int n = 0; n < exp_n; n++) begin
      start = (n == 0); stall = stall_at[n];
      tick();
      checks++;
      if (obs !== exp_a[n]) begin
        errors++;
        if (errors < 40) $display("FAIL rand_stall_trace cyc=%0d got=%h exp=%h", n, obs, exp_a[n]);
      end
      if (obs.done === 1'b1) dcount++;
    end
    start = 1'b0; stall = 1'b0;
    checks++;
    if (dcount != 1) begin errors++; $display("FAIL rand_stall_done got=%0d exp=1", dcount); end
  endtask

  task automatic test_second_start();
    int dcount = 0, dcyc = -1;
    clear_stalls();
    build_model();
    for (int n = 0; n < exp_n; n++) begin
      start = (n == 0 || n == 51); stall = 1'b0;
      tick();
      checks++;
      if (obs !== exp_a[n]) begin
        errors++;
        if (errors < 40) $display("FAIL second_start_trace cyc=%0d got=%h exp=%h", n, obs, exp_a[n]);
      end
      if (obs.done === 1'b1) begin dcount++; dcyc = n; end
    end
    start = 1'b0;
    checks++;
    if (dcount != 1 || dcyc != 1102) begin errors++; $display("FAIL second_start_done got count=%0d cyc=%0d exp 1/1102", dcount, dcyc); end
  endtask

  task automatic test_rst_mid();
    int dcount = 0;
    clear_stalls();
    build_model();
    for (int n = 0; n <= 91; n++) begin
      start = (n == 0); stall = 1'b0; rst = (n == 91);
      tick();
      if (n < 91) begin
        checks++;
        if (obs !== exp_a[n]) begin
          errors++;
          if (errors < 40) $display("FAIL rst_mid_trace cyc=%0d got=%h exp=%h", n, obs, exp_a[n]);
        end
      end
      if (obs.done === 1'b1) dcount++;
    end
    rst = 1'b0; start = 1'b0;
    checks++;
    if (obs !== rec_t'(0) || cycle_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_mid_clear got=%h cnt=%0d exp=0", obs, cycle_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (obs.done === 1'b1) dcount++;
      checks++;
      if (obs.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got busy=%b exp=0", obs.busy); end
    end
    checks++;
    if (dcount != 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d exp=0", dcount); end
    test_nominal();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall_window();
    test_random_stall();
    test_second_start();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
